regfile_scoreboard: RTL and testbench

//   Parametrised integer register file with write-back port and per-register

---
 rtl/regfile_scoreboard_pkg.sv | 9 +
 rtl/regfile_scoreboard_sb_counter.sv | 21 ++
 rtl/regfile_scoreboard.sv | 68 ++++++
 tb/tb_regfile_scoreboard.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg: shared core constants for the register file and scoreboard.
package regfile_scoreboard_pkg;
  localparam int DEF_XLEN     = 32;
  localparam int DEF_NREGS    = 32;
  localparam int DEF_NREAD    = 2;
  localparam int DEF_MAX_PEND = 3;
  localparam int DEF_BYPASS   = 1;
  localparam int REG_ZERO     = 0;
endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// sb_counter: per-register pending-write counter with increment, decrement and clear.
module sb_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          dec_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  // inc and dec together cancel; clear overrides both
  assign cnt_d = clr_i ? '0 :
                 (inc_i && !dec_i) ? cnt_q + 1'b1 :
                 (dec_i && !inc_i) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with N read ports, WB bypass and pending-write scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NREAD    = DEF_NREAD,
  parameter int MAX_PEND = DEF_MAX_PEND,
  parameter int BYPASS   = DEF_BYPASS,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rd_addr_i,
  output logic [NREAD*XLEN-1:0] rd_data_o,
  output logic [NREAD-1:0]      rd_busy_o,
  input  logic                  issue_valid_i,
  input  logic [AW-1:0]         issue_rd_i,
  output logic                  issue_ready_o,
  input  logic                  wb_valid_i,
  input  logic [AW-1:0]         wb_rd_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic                  flush_i,
  output logic                  busy_any_o,
  output logic                  wb_err_o
);
  localparam int CW = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_PEND);
  localparam logic [AW-1:0] X0 = AW'(REG_ZERO);
  logic [XLEN-1:0] regs_q [NREGS];
  logic [CW-1:0]   cnt [NREGS];
  logic            wb_en, issue_acc, wb_err_q;
  assign wb_en         = wb_valid_i && wb_rd_i != X0;
  // readiness uses pre-retirement counts, so a same-cycle WB never frees a full slot
  assign issue_ready_o = !(issue_rd_i != X0 && cnt[issue_rd_i] == CMAX) && !flush_i;
  assign issue_acc     = issue_valid_i && issue_ready_o && issue_rd_i != X0;
  assign cnt[0]        = '0;
  for (genvar g = 1; g < NREGS; g++) begin : g_cnt
    sb_counter #(.CW(CW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (issue_acc && issue_rd_i == AW'(g)),
      .dec_i (wb_en && wb_rd_i == AW'(g) && cnt[g] != '0),
      .clr_i (flush_i),
      .cnt_o (cnt[g])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    else if (wb_en) regs_q[wb_rd_i] <= wb_data_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wb_err_q <= 1'b0;
    else if (wb_en && cnt[wb_rd_i] == '0 && !flush_i) wb_err_q <= 1'b1;
  assign wb_err_o = wb_err_q;
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a   = rd_addr_i[p*AW +: AW];
    assign hit = BYPASS != 0 && wb_en && wb_rd_i == a;
    assign rd_data_o[p*XLEN +: XLEN] = a == X0 ? '0 : hit ? wb_data_i : regs_q[a];
    // a forwarded value retiring the last pending write is final
    assign rd_busy_o[p] = a != X0 && cnt[a] != '0 && !(hit && cnt[a] == CW'(1));
  end
  always_comb begin
    busy_any_o = 1'b0;
    for (int i = 0; i < NREGS; i++) busy_any_o = busy_any_o | (|cnt[i]);
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and randomized checks of both bypass variants against a reference model.
module tb_regfile_scoreboard;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic        issue_valid = 1'b0, wb_valid = 1'b0, flush = 1'b0;
  logic [4:0]  issue_rd = '0, wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        ready_a, ready_b, any_a, any_b, err_a, err_b;
  int n_chk = 0, n_fail = 0;
  int          m_cnt [32];
  logic [31:0] m_mem [32];
  bit          m_err;

  always #5 clk = ~clk;

  regfile_scoreboard #(.BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(ready_a),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data), .flush_i(flush),
    .busy_any_o(any_a), .wb_err_o(err_a));
  regfile_scoreboard #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(ready_b),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data), .flush_i(flush),
    .busy_any_o(any_b), .wb_err_o(err_b));

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin m_cnt[i] = 0; m_mem[i] = '0; end
    m_err = 0;
  endtask

  function automatic logic [31:0] m_rd(int a, bit byp);
    if (a == 0) return '0;
    if (byp && wb_valid && int'(wb_rd) == a) return wb_data;
    return m_mem[a];
  endfunction

  function automatic bit m_busy(int a, bit byp);
    if (a == 0) return 0;
    if (byp && wb_valid && int'(wb_rd) == a && m_cnt[a] == 1) return 0;
    return m_cnt[a] != 0;
  endfunction

  function automatic bit m_ready();
    return !(issue_rd != 0 && m_cnt[issue_rd] == 3) && !flush;
  endfunction

  function automatic bit m_any();
    for (int i = 0; i < 32; i++) if (m_cnt[i] != 0) return 1;
    return 0;
  endfunction

  task automatic m_update();
    bit acc, wen, dec;
    acc = issue_valid && m_ready() && issue_rd != 0;
    wen = wb_valid && wb_rd != 0;
    dec = wen && m_cnt[wb_rd] > 0;
    if (wen) begin
      if (m_cnt[wb_rd] == 0 && !flush) m_err = 1;
      m_mem[wb_rd] = wb_data;
    end
    if (flush) for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    else begin
      if (acc) m_cnt[issue_rd]++;
      if (dec) m_cnt[wb_rd]--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask

  task automatic test_reset();
    idle(); issue_valid = 1; issue_rd = 6; wb_valid = 1; wb_rd = 5; wb_data = 32'hA5;
    tick();
    idle(); rd_addr = {5'd6, 5'd5};
    #3 rst_n = 0; m_reset();
    #1;
    n_chk++; if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h/%h exp 0", rd_data_a, rd_data_b); end
    n_chk++; if (rd_busy_a !== 2'b00 || rd_busy_b !== 2'b00) begin n_fail++; $display("FAIL reset_rd_busy: got %b/%b exp 00", rd_busy_a, rd_busy_b); end
    n_chk++; if (any_a !== 1'b0 || any_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_any: got %b/%b exp 0", any_a, any_b); end
    n_chk++; if (ready_a !== 1'b1 || ready_b !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b/%b exp 1", ready_a, ready_b); end
    n_chk++; if (err_a !== 1'b0 || err_b !== 1'b0) begin n_fail++; $display("FAIL reset_wb_err: got %b/%b exp 0", err_a, err_b); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    idle(); issue_valid = 1; issue_rd = 5; tick();
    idle(); wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; tick();
    idle(); rd_addr = {5'd0, 5'd5}; #1;
    n_chk++; if (rd_data_a[31:0] !== 32'hDEADBEEF || rd_data_b[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_x5: got %h/%h exp deadbeef", rd_data_a[31:0], rd_data_b[31:0]); end
    wb_valid = 1; wb_rd = 0; wb_data = 32'h1234; tick();
    idle(); rd_addr = {5'd0, 5'd0}; #1;
    n_chk++; if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin n_fail++; $display("FAIL basic_rd_x0: got %h/%h exp 0", rd_data_a, rd_data_b); end
    n_chk++; if (err_a !== 1'b0 || err_b !== 1'b0) begin n_fail++; $display("FAIL basic_wb_err: got %b/%b exp 0", err_a, err_b); end
  endtask

  task automatic test_scoreboard();
    idle(); issue_valid = 1; issue_rd = 7;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL sb_ready_%0d: got %b exp 1", k, ready_a); end
      tick();
    end
    #1;
    n_chk++; if (ready_a !== 1'b0 || ready_b !== 1'b0) begin n_fail++; $display("FAIL sb_ready_full: got %b/%b exp 0", ready_a, ready_b); end
    tick();
    idle(); wb_valid = 1; wb_rd = 7; wb_data = 32'h11; tick();
    idle(); rd_addr = {5'd7, 5'd7}; #1;
    n_chk++; if (rd_busy_a !== 2'b11 || rd_busy_b !== 2'b11) begin n_fail++; $display("FAIL sb_busy_cnt2: got %b/%b exp 11", rd_busy_a, rd_busy_b); end
    n_chk++; if (rd_data_a[31:0] !== 32'h11) begin n_fail++; $display("FAIL sb_data: got %h exp 11", rd_data_a[31:0]); end
    wb_valid = 1; wb_rd = 7; wb_data = 32'h22; tick(); tick();
    idle(); #1;
    n_chk++; if (rd_busy_a !== 2'b00 || rd_busy_b !== 2'b00) begin n_fail++; $display("FAIL sb_busy_drained: got %b/%b exp 00", rd_busy_a, rd_busy_b); end
    n_chk++; if (any_a !== 1'b0 || any_b !== 1'b0) begin n_fail++; $display("FAIL sb_busy_any: got %b/%b exp 0", any_a, any_b); end
  endtask

  task automatic test_bypass();
    idle(); issue_valid = 1; issue_rd = 9; tick();
    idle(); wb_valid = 1; wb_rd = 9; wb_data = 32'hCAFE; rd_addr = {5'd9, 5'd9}; #1;
    n_chk++; if (rd_data_a !== {2{32'hCAFE}}) begin n_fail++; $display("FAIL byp_data: got %h exp %h", rd_data_a, {2{32'hCAFE}}); end
    n_chk++; if (rd_busy_a !== 2'b00) begin n_fail++; $display("FAIL byp_busy: got %b exp 00", rd_busy_a); end
    n_chk++; if (rd_data_b !== {2{m_rd(9, 0)}}) begin n_fail++; $display("FAIL nobyp_data: got %h exp %h", rd_data_b, {2{m_rd(9, 0)}}); end
    n_chk++; if (rd_busy_b !== 2'b11) begin n_fail++; $display("FAIL nobyp_busy: got %b exp 11", rd_busy_b); end
    tick(); idle();
  endtask

  task automatic test_collision();
    idle(); issue_valid = 1; issue_rd = 3; tick();
    wb_valid = 1; wb_rd = 3; wb_data = 32'h33; tick();
    idle(); rd_addr = {5'd4, 5'd3}; #1;
    n_chk++; if (rd_busy_a[0] !== 1'b1 || m_cnt[3] != 1) begin n_fail++; $display("FAIL coll_busy: got %b exp 1", rd_busy_a[0]); end
    n_chk++; if (rd_data_a[31:0] !== 32'h33) begin n_fail++; $display("FAIL coll_data: got %h exp 33", rd_data_a[31:0]); end
    issue_valid = 1; issue_rd = 4; tick();
    flush = 1; wb_valid = 1; wb_rd = 10; wb_data = 32'hF00D; #1;
    n_chk++; if (ready_a !== 1'b0 || ready_b !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b/%b exp 0", ready_a, ready_b); end
    tick();
    idle(); #1;
    n_chk++; if (any_a !== 1'b0 || any_b !== 1'b0 || rd_busy_a !== 2'b00) begin n_fail++; $display("FAIL flush_clear: got any %b/%b busy %b exp 0/0/00", any_a, any_b, rd_busy_a); end
    n_chk++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL flush_no_err: got %b exp 0", err_a); end
  endtask

  task automatic test_error();
    idle(); wb_valid = 1; wb_rd = 12; wb_data = 32'hBAD1; tick();
    idle(); rd_addr = {5'd12, 5'd12}; #1;
    n_chk++; if (err_a !== 1'b1 || err_b !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b/%b exp 1", err_a, err_b); end
    n_chk++; if (rd_data_a[31:0] !== 32'hBAD1) begin n_fail++; $display("FAIL err_data: got %h exp bad1", rd_data_a[31:0]); end
    flush = 1; tick(); idle(); tick(); tick(); #1;
    n_chk++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b exp 1", err_a); end
    #2 rst_n = 0; m_reset(); #1;
    n_chk++; if (err_a !== 1'b0 || rd_data_a !== 64'h0) begin n_fail++; $display("FAIL err_reset: got err %b data %h exp 0", err_a, rd_data_a); end
    @(negedge clk); rst_n = 1; @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      issue_valid = $urandom_range(0, 1);
      issue_rd    = 5'($urandom_range(0, 6));
      wb_valid    = $urandom_range(0, 2) != 0;
      wb_rd       = 5'($urandom_range(0, 6));
      wb_data     = $urandom;
      flush       = $urandom_range(0, 19) == 0;
      rd_addr     = {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))};
      #1;
      for (int p = 0; p < 2; p++) begin
        n_chk++; if (rd_data_a[p*32 +: 32] !== m_rd(rd_addr[p*5 +: 5], 1)) begin n_fail++; $display("FAIL rnd_data_byp c%0d p%0d: got %h exp %h", c, p, rd_data_a[p*32 +: 32], m_rd(rd_addr[p*5 +: 5], 1)); end
        n_chk++; if (rd_data_b[p*32 +: 32] !== m_rd(rd_addr[p*5 +: 5], 0)) begin n_fail++; $display("FAIL rnd_data_nobyp c%0d p%0d: got %h exp %h", c, p, rd_data_b[p*32 +: 32], m_rd(rd_addr[p*5 +: 5], 0)); end
        n_chk++; if (rd_busy_a[p] !== m_busy(rd_addr[p*5 +: 5], 1)) begin n_fail++; $display("FAIL rnd_busy_byp c%0d p%0d: got %b exp %b", c, p, rd_busy_a[p], m_busy(rd_addr[p*5 +: 5], 1)); end
        n_chk++; if (rd_busy_b[p] !== m_busy(rd_addr[p*5 +: 5], 0)) begin n_fail++; $display("FAIL rnd_busy_nobyp c%0d p%0d: got %b exp %b", c, p, rd_busy_b[p], m_busy(rd_addr[p*5 +: 5], 0)); end
      end
      n_chk++; if (ready_a !== m_ready() || ready_b !== m_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b/%b exp %b", c, ready_a, ready_b, m_ready()); end
      n_chk++; if (any_a !== m_any() || any_b !== m_any()) begin n_fail++; $display("FAIL rnd_busy_any c%0d: got %b/%b exp %b", c, any_a, any_b, m_any()); end
      n_chk++; if (err_a !== m_err || err_b !== m_err) begin n_fail++; $display("FAIL rnd_wb_err c%0d: got %b/%b exp %b", c, err_a, err_b, m_err); end
      tick();
    end
    idle();
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_scoreboard();
    test_bypass();
    test_collision();
    test_error();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
